// File: rtl/pipe_issue_sched_pkg.sv
// Shared types and constants for the pipeline issue scheduler.
package pipe_issue_pkg;

    // Opcodes of the 8-bit instruction word {op, rs1, rs2, rd}
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // Field positions inside the instruction word
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RS1_MSB = 5;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 2;
    localparam int RD_MSB  = 1;
    localparam int RD_LSB  = 0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } state_t;

    // In-flight tag travelling alongside an instruction
    typedef struct packed {
        logic valid;
        logic src;
    } tag_t;

endpackage

// File: rtl/pipe_issue_sched_if.sv
// Requester handshake bundle: two valid/inst/ready channels.
interface pipe_issue_sched_if;
    logic       req0_valid;
    logic [7:0] req0_inst;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_inst;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_inst, req1_valid, req1_inst,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_inst, req1_valid, req1_inst,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/pipe_issue_sched_tracker.sv
// Three-stage tag shift register mirroring the ID/EX/WB pipeline stages.
module pipe_inflight_tracker
    import pipe_issue_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  tag_t load_tag,
    output tag_t wb_tag,
    output logic empty
);

    tag_t id_r;
    tag_t ex_r;
    tag_t wb_r;

    // Shift tags one stage per cycle; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            id_r <= 2'b00;
            ex_r <= 2'b00;
            wb_r <= 2'b00;
        end else begin
            id_r <= load_tag;
            ex_r <= id_r;
            wb_r <= ex_r;
        end
    end

    assign wb_tag = wb_r;
    // Only the WB instruction (retiring now) may remain: once it writes back at
    // the end of this cycle, all three stages are empty while issue is blocked.
    assign empty  = !id_r.valid && !ex_r.valid;

endmodule

// File: rtl/pipe_issue_sched.sv
// Round-robin instruction issue scheduler with retire tracking and drain handshake.
module pipe_issue_sched
    import pipe_issue_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [7:0] NOP_INST = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    pipe_issue_sched_if.slave  req,
    input  logic               drain_req,
    output logic               drained,
    output logic [7:0]         pipe_inst,
    output logic               retire_valid,
    output logic               retire_src,
    output logic [CNT_W-1:0]   retire_cnt0,
    output logic [CNT_W-1:0]   retire_cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_state_s;
    logic             last_grant_r;
    logic             grant0_s;
    logic             grant1_s;
    logic [7:0]       pipe_inst_r;
    logic             drained_r;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;
    tag_t             load_tag_s;
    tag_t             wb_tag_s;
    logic             empty_s;

    // Round-robin arbitration; nothing is granted outside RUN or while drain is requested
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == RUN) && !drain_req) begin
            if (req.req0_valid && (!req.req1_valid || last_grant_r)) begin
                grant0_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
            end
            if (req.req1_valid && (!req.req0_valid || !last_grant_r)) begin
                grant1_s = 1'b1;
            end else begin
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req.req0_ready   = grant0_s;
    assign req.req1_ready   = grant1_s;
    assign load_tag_s.valid = grant0_s | grant1_s;
    assign load_tag_s.src   = grant1_s;

    // Drain FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RUN: begin
                if (drain_req) next_state_s = DRAIN;
                else           next_state_s = RUN;
            end
            DRAIN: begin
                if (empty_s) next_state_s = DRAINED;
                else         next_state_s = DRAIN;
            end
            DRAINED: begin
                if (!drain_req) next_state_s = RUN;
                else            next_state_s = DRAINED;
            end
            default: next_state_s = RUN;
        endcase
    end

    // State, grant history, issued instruction and drained flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            last_grant_r <= 1'b1;
            pipe_inst_r  <= NOP_INST;
            drained_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            drained_r <= (next_state_s == DRAINED);
            if (grant0_s) begin
                last_grant_r <= 1'b0;
                pipe_inst_r  <= req.req0_inst;
            end else if (grant1_s) begin
                last_grant_r <= 1'b1;
                pipe_inst_r  <= req.req1_inst;
            end else begin
                pipe_inst_r  <= NOP_INST;
            end
        end
    end

    // Saturating per-source retire counters, updated the cycle after WB
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (wb_tag_s.valid && !wb_tag_s.src && (cnt0_r != CNT_MAX)) begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end
            if (wb_tag_s.valid && wb_tag_s.src && (cnt1_r != CNT_MAX)) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end
        end
    end

    pipe_inflight_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .load_tag (load_tag_s),
        .wb_tag   (wb_tag_s),
        .empty    (empty_s)
    );

    assign pipe_inst    = pipe_inst_r;
    assign drained      = drained_r;
    assign retire_valid = wb_tag_s.valid;
    assign retire_src   = wb_tag_s.src;
    assign retire_cnt0  = cnt0_r;
    assign retire_cnt1  = cnt1_r;

endmodule

// File: tb/tb_pipe_issue_sched.sv
// Scoreboard bench for pipe_issue_sched: directed stimulus, decoupled monitor.
module tb_pipe_issue_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drain_req = 1'b0;
    logic        drain_sat = 1'b0;
    logic        mon_en = 1'b0;

    logic        drained, retire_valid, retire_src;
    logic [7:0]  pipe_inst;
    logic [15:0] retire_cnt0, retire_cnt1;

    logic        drained_sat, retire_valid_sat, retire_src_sat;
    logic [7:0]  pipe_inst_sat;
    logic [1:0]  retire_cnt0_sat, retire_cnt1_sat;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_inst_q[$];
    logic        exp_src_q[$];
    logic [7:0]  mon_inst;
    logic        mon_src;

    pipe_issue_sched_if bus ();
    pipe_issue_sched_if bus_sat ();

    pipe_issue_sched #(.CNT_W(16), .NOP_INST(8'h00)) dut (
        .clk(clk), .rst(rst), .req(bus), .drain_req(drain_req), .drained(drained),
        .pipe_inst(pipe_inst), .retire_valid(retire_valid), .retire_src(retire_src),
        .retire_cnt0(retire_cnt0), .retire_cnt1(retire_cnt1)
    );

    pipe_issue_sched #(.CNT_W(2), .NOP_INST(8'h00)) dut_sat (
        .clk(clk), .rst(rst), .req(bus_sat), .drain_req(drain_sat), .drained(drained_sat),
        .pipe_inst(pipe_inst_sat), .retire_valid(retire_valid_sat), .retire_src(retire_src_sat),
        .retire_cnt0(retire_cnt0_sat), .retire_cnt1(retire_cnt1_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] i0,
                         input logic v1, input logic [7:0] i1, input logic dr);
        bus.req0_valid = v0;
        bus.req0_inst  = i0;
        bus.req1_valid = v1;
        bus.req1_inst  = i1;
        drain_req      = dr;
        #1;
    endtask

    task automatic expect_issue(input logic [7:0] inst, input logic src);
        exp_inst_q.push_back(inst);
        exp_src_q.push_back(src);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every non-NOP issue and every retire pulse must match the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (pipe_inst != 8'h00) begin
                if (exp_inst_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_issue: got %0h expected no issue", pipe_inst);
                end else begin
                    mon_inst = exp_inst_q.pop_front();
                    check("sb_issue", {24'h0, pipe_inst}, {24'h0, mon_inst});
                end
            end
            if (retire_valid) begin
                if (exp_src_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_retire: got src %0d expected no retire", retire_src);
                end else begin
                    mon_src = exp_src_q.pop_front();
                    check("sb_retire_src", {31'h0, retire_src}, {31'h0, mon_src});
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Directed stimulus
    initial begin
        logic [1:0] sat_exp [9];
        sat_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        bus_sat.req0_valid = 1'b0;
        bus_sat.req0_inst  = 8'h00;
        bus_sat.req1_valid = 1'b0;
        bus_sat.req1_inst  = 8'h00;

        // Reset values
        tick();
        tick();
        check("rst_pipe_inst", {24'h0, pipe_inst}, 32'h00);
        check("rst_drained", {31'h0, drained}, 32'h0);
        check("rst_retire_valid", {31'h0, retire_valid}, 32'h0);
        check("rst_retire_src", {31'h0, retire_src}, 32'h0);
        check("rst_cnt0", {16'h0, retire_cnt0}, 32'h0);
        check("rst_cnt1", {16'h0, retire_cnt1}, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // A: both valid continuously -> grants 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h47, 1'b1, 8'h86, 1'b0);
            check("A_ready0", {31'h0, bus.req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check("A_ready1", {31'h0, bus.req1_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
            if (i % 2 == 0) expect_issue(8'h47, 1'b0);
            else            expect_issue(8'h86, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check("A_idle_nop", {24'h0, pipe_inst}, 32'h00);
        repeat (4) tick();
        check("A_cnt0", {16'h0, retire_cnt0}, 32'd2);
        check("A_cnt1", {16'h0, retire_cnt1}, 32'd2);

        // B: only req1 for 4 cycles, from a fresh reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'h9B, 1'b0);
            check("B_ready1", {31'h0, bus.req1_ready}, 32'h1);
            check("B_ready0", {31'h0, bus.req0_ready}, 32'h0);
            expect_issue(8'h9B, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check("B_idle_nop", {24'h0, pipe_inst}, 32'h00);
        tick();
        check("B_cnt1_t6", {16'h0, retire_cnt1}, 32'd3);
        tick();
        check("B_cnt1_t7", {16'h0, retire_cnt1}, 32'd4);
        check("B_cnt0_t7", {16'h0, retire_cnt0}, 32'd0);

        // C: accept at t, drain held from t+1, release at t+6
        drive(1'b1, 8'hD7, 1'b0, 8'h00, 1'b0);
        check("C_ready0_t", {31'h0, bus.req0_ready}, 32'h1);
        expect_issue(8'hD7, 1'b0);
        tick();
        drive(1'b1, 8'hD7, 1'b1, 8'h86, 1'b1);
        check("C_ready0_t1", {31'h0, bus.req0_ready}, 32'h0);
        check("C_ready1_t1", {31'h0, bus.req1_ready}, 32'h0);
        tick();
        check("C_ready0_t2", {31'h0, bus.req0_ready}, 32'h0);
        check("C_drained_t2", {31'h0, drained}, 32'h0);
        tick();
        check("C_drained_t3", {31'h0, drained}, 32'h0);
        tick();
        check("C_drained_t4", {31'h0, drained}, 32'h1);
        tick();
        check("C_drained_t5", {31'h0, drained}, 32'h1);
        check("C_ready1_t5", {31'h0, bus.req1_ready}, 32'h0);
        tick();
        drive(1'b1, 8'hD7, 1'b1, 8'h86, 1'b0);
        check("C_drained_t6", {31'h0, drained}, 32'h1);
        check("C_ready0_t6", {31'h0, bus.req0_ready}, 32'h0);
        tick();
        check("C_drained_t7", {31'h0, drained}, 32'h0);
        check("C_ready1_t7", {31'h0, bus.req1_ready}, 32'h1);
        check("C_ready0_t7", {31'h0, bus.req0_ready}, 32'h0);
        expect_issue(8'h86, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (4) tick();

        // D: one-cycle drain pulse with two instructions in flight
        drive(1'b1, 8'h5B, 1'b0, 8'h00, 1'b0);
        check("D_ready0", {31'h0, bus.req0_ready}, 32'h1);
        expect_issue(8'h5B, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 8'hE4, 1'b0);
        check("D_ready1", {31'h0, bus.req1_ready}, 32'h1);
        expect_issue(8'hE4, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("D_drained_c3", {31'h0, drained}, 32'h0);
        tick();
        check("D_drained_c4", {31'h0, drained}, 32'h0);
        tick();
        check("D_drained_c5", {31'h0, drained}, 32'h1);
        tick();
        check("D_drained_c6", {31'h0, drained}, 32'h0);
        repeat (3) tick();
        check("D_cnt0", {16'h0, retire_cnt0}, 32'd2);
        check("D_cnt1", {16'h0, retire_cnt1}, 32'd6);

        // E: reset while draining with two tags in flight
        drive(1'b1, 8'h47, 1'b0, 8'h00, 1'b0);
        check("E_ready0_e0", {31'h0, bus.req0_ready}, 32'h1);
        expect_issue(8'h47, 1'b0);
        tick();
        drive(1'b1, 8'h5B, 1'b0, 8'h00, 1'b0);
        check("E_ready0_e1", {31'h0, bus.req0_ready}, 32'h1);
        expect_issue(8'h5B, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        rst = 1'b1;
        check("E_drained_e3", {31'h0, drained}, 32'h0);
        tick();
        check("E_pipe_inst", {24'h0, pipe_inst}, 32'h00);
        check("E_retire_valid", {31'h0, retire_valid}, 32'h0);
        check("E_cnt0", {16'h0, retire_cnt0}, 32'h0);
        check("E_cnt1", {16'h0, retire_cnt1}, 32'h0);
        check("E_drained", {31'h0, drained}, 32'h0);
        exp_inst_q.delete();
        exp_src_q.delete();
        rst = 1'b0;
        drive(1'b1, 8'h47, 1'b1, 8'h86, 1'b0);
        check("E_ready0_post", {31'h0, bus.req0_ready}, 32'h1);
        check("E_ready1_post", {31'h0, bus.req1_ready}, 32'h0);
        expect_issue(8'h47, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (4) tick();
        check("E_cnt0_after", {16'h0, retire_cnt0}, 32'd1);
        check("E_cnt1_after", {16'h0, retire_cnt1}, 32'd0);

        // F: CNT_W=2 instance, five req0 instructions -> 1,2,3,3,3
        bus_sat.req0_valid = 1'b1;
        bus_sat.req0_inst  = 8'h47;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) bus_sat.req0_valid = 1'b0;
            if (k >= 3) check($sformatf("F_sat_cnt0_k%0d", k),
                              {30'h0, retire_cnt0_sat}, {30'h0, sat_exp[k]});
        end

        tick();
        check("sb_inst_drained", exp_inst_q.size(), 32'd0);
        check("sb_src_drained", exp_src_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
